reg_file_mp: RTL and testbench

//  Parametrised multi-port integer register file for the RISC-V datapath; successor to the 32x32 2R1W file.

---
 rtl/reg_file_mp.sv | 93 +++++++++
 tb/tb_reg_file_mp.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_mp.sv
// reg_file_mp: parametrised multi-port integer register file.
// NREAD combinational read ports, two synchronous write ports (3 and 4),
// optional hardwired zero register, self-clearing after reset.
// READY goes high once every register has been cleared.
// Optional feature macro: RF_BYPASS_EN (same-cycle write-to-read forwarding).
module reg_file_mp #(
   parameter int XLEN     = 32,
   parameter int NREGS    = 32,
   parameter int NREAD    = 2,
   parameter int ZERO_REG = 1,
   localparam int AW      = $clog2(NREGS)
) (
   input  logic                   CLK,
   input  logic                   RST,
   input  logic [NREAD*AW-1:0]    A,
   output logic [NREAD*XLEN-1:0]  RD,
   input  logic [AW-1:0]          A3,
   input  logic [XLEN-1:0]        WD3,
   input  logic                   WE3,
   input  logic [AW-1:0]          A4,
   input  logic [XLEN-1:0]        WD4,
   input  logic                   WE4,
   output logic                   READY
);

   typedef enum logic {S_CLEAR, S_READY} state_t;

   localparam logic [AW-1:0] LAST    = AW'(NREGS - 1);
   localparam logic [AW:0]   NREGS_W = (AW + 1)'(NREGS);

   state_t               state;
   logic [AW-1:0]        clr_cnt;
   logic [XLEN-1:0]      rf [NREGS];
   logic                 wr3_ok;
   logic                 wr4_ok;

   // An address is writable/readable if it is in range and not the hardwired zero register
   function automatic logic legal(input logic [AW-1:0] addr);
      legal = ({1'b0, addr} < NREGS_W) && !((ZERO_REG != 0) && (addr == '0));
   endfunction

   assign wr3_ok = WE3 && legal(A3);
   assign wr4_ok = WE4 && legal(A4);

   // Clear sequencer and write ports; array is left untouched while RST is high
   always_ff @(posedge CLK) begin
      if (RST) begin
         state   <= S_CLEAR;
         clr_cnt <= '0;
         READY   <= 1'b0;
      end else begin
         case (state)
            S_CLEAR: begin
               rf[clr_cnt] <= '0;
               if (clr_cnt == LAST) begin
                  state <= S_READY;
                  READY <= 1'b1;
               end else begin
                  clr_cnt <= clr_cnt + 1'b1;
               end
            end
            S_READY: begin
               // Port 4 is assigned last so it wins a same-address collision
               if (wr3_ok) rf[A3] <= WD3;
               if (wr4_ok) rf[A4] <= WD4;
            end
            default: begin
               state <= S_CLEAR;
               READY <= 1'b0;
            end
         endcase
      end
   end

   // Combinational read ports, forced to zero until the clear sequence completes
   always_comb begin
      logic [AW-1:0] ra;
      ra = '0;
      RD = '0;
      for (int unsigned i = 0; i < NREAD; i++) begin
         ra = A[i*AW +: AW];
         if (READY && legal(ra)) begin
            RD[i*XLEN +: XLEN] = rf[ra];
`ifdef RF_BYPASS_EN
            // Forward same-cycle writes; port 4 checked last so it has priority
            if (WE3 && (A3 == ra)) RD[i*XLEN +: XLEN] = WD3;
            if (WE4 && (A4 == ra)) RD[i*XLEN +: XLEN] = WD4;
`endif
         end
      end
   end

endmodule

// File: tb/tb_reg_file_mp.sv
// Directed self-checking bench for reg_file_mp.
// dut:    32 registers, zero register hardwired.
// dut_nz: 24 registers, zero register ordinary (addresses 24..31 out of range).
module tb_reg_file_mp;

   logic        CLK = 1'b0;
   logic        RST;
   logic [9:0]  A;
   logic [4:0]  A3, A4;
   logic [31:0] WD3, WD4;
   logic        WE3, WE4;
   logic [63:0] rd, rd_nz;
   logic        ready, ready_nz;

   int errors = 0;
   int checks = 0;

   always #5 CLK = ~CLK;

   reg_file_mp #(.XLEN(32), .NREGS(32), .NREAD(2), .ZERO_REG(1)) dut (
      .CLK(CLK), .RST(RST), .A(A), .RD(rd),
      .A3(A3), .WD3(WD3), .WE3(WE3),
      .A4(A4), .WD4(WD4), .WE4(WE4),
      .READY(ready)
   );

   reg_file_mp #(.XLEN(32), .NREGS(24), .NREAD(2), .ZERO_REG(0)) dut_nz (
      .CLK(CLK), .RST(RST), .A(A), .RD(rd_nz),
      .A3(A3), .WD3(WD3), .WE3(WE3),
      .A4(A4), .WD4(WD4), .WE4(WE4),
      .READY(ready_nz)
   );

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic set_ra(input logic [4:0] a0, input logic [4:0] a1);
      A = {a1, a0};
      #1;
   endtask

   // Runs a fixed 40-cycle window and records the first cycle each READY is seen high
   task automatic wait_ready(output int n32, output int n24);
      n32 = 0;
      n24 = 0;
      for (int k = 1; k <= 40; k++) begin
         tick();
         if (ready && n32 == 0) n32 = k;
         if (ready_nz && n24 == 0) n24 = k;
      end
   endtask

   task automatic test_reset();
      int n32, n24;
      RST = 1'b1; WE3 = 1'b0; WE4 = 1'b0;
      A3 = '0; A4 = '0; WD3 = '0; WD4 = '0;
      set_ra(5'd3, 5'd4);
      tick(); tick();
      checks++;
      if (ready !== 1'b0 || ready_nz !== 1'b0) begin
         errors++; $display("FAIL reset_ready: got %b/%b expected 0/0", ready, ready_nz);
      end
      checks++;
      if (rd !== 64'h0) begin
         errors++; $display("FAIL reset_rd: got %h expected 0", rd);
      end
      RST = 1'b0;
      wait_ready(n32, n24);
      checks++;
      if (n32 != 32) begin
         errors++; $display("FAIL clear_len32: got %0d expected 32", n32);
      end
      checks++;
      if (n24 != 24) begin
         errors++; $display("FAIL clear_len24: got %0d expected 24", n24);
      end
      for (int a = 0; a < 32; a++) begin
         set_ra(5'(a), 5'(31 - a));
         checks++;
         if (rd !== 64'h0 || rd_nz !== 64'h0) begin
            errors++; $display("FAIL clear_zero[%0d]: got %h/%h expected 0", a, rd, rd_nz);
         end
      end
   endtask

   task automatic test_write_read();
      A3 = 5'd5; WD3 = 32'hDEADBEEF; WE3 = 1'b1;
      A4 = 5'd12; WD4 = 32'h12345678; WE4 = 1'b1;
      tick();
      WE3 = 1'b0; WE4 = 1'b0;
      set_ra(5'd5, 5'd5);
      checks++;
      if (rd !== {32'hDEADBEEF, 32'hDEADBEEF}) begin
         errors++; $display("FAIL wr_rd_r5: got %h expected deadbeefdeadbeef", rd);
      end
      checks++;
      if (rd_nz[31:0] !== 32'hDEADBEEF) begin
         errors++; $display("FAIL wr_rd_r5_nz: got %h expected deadbeef", rd_nz[31:0]);
      end
      set_ra(5'd12, 5'd5);
      checks++;
      if (rd !== {32'hDEADBEEF, 32'h12345678}) begin
         errors++; $display("FAIL wr_rd_r12: got %h expected deadbeef12345678", rd);
      end
   endtask

   task automatic test_zero_reg();
      A3 = 5'd0; WD3 = 32'hFFFFFFFF; WE3 = 1'b1;
      tick();
      WE3 = 1'b0;
      set_ra(5'd0, 5'd5);
      checks++;
      if (rd[31:0] !== 32'h0) begin
         errors++; $display("FAIL zero_reg: got %h expected 0", rd[31:0]);
      end
      checks++;
      if (rd_nz[31:0] !== 32'hFFFFFFFF) begin
         errors++; $display("FAIL zero_reg_off: got %h expected ffffffff", rd_nz[31:0]);
      end
   endtask

   task automatic test_collision();
      A3 = 5'd7; WD3 = 32'h11; WE3 = 1'b1;
      A4 = 5'd7; WD4 = 32'h22; WE4 = 1'b1;
      tick();
      A3 = 5'd8; WD3 = 32'h88;
      A4 = 5'd9; WD4 = 32'h99;
      tick();
      WE3 = 1'b0; WE4 = 1'b0;
      set_ra(5'd7, 5'd7);
      checks++;
      if (rd !== {32'h22, 32'h22} || rd_nz !== {32'h22, 32'h22}) begin
         errors++; $display("FAIL collision_r7: got %h/%h expected 0x22 both", rd, rd_nz);
      end
      set_ra(5'd8, 5'd9);
      checks++;
      if (rd !== {32'h99, 32'h88}) begin
         errors++; $display("FAIL dual_write: got %h expected 0000009900000088", rd);
      end
   endtask

   task automatic test_out_of_range();
      A3 = 5'd25; WD3 = 32'h00000BAD; WE3 = 1'b1;
      tick();
      WE3 = 1'b0;
      set_ra(5'd25, 5'd1);
      checks++;
      if (rd_nz !== 64'h0) begin
         errors++; $display("FAIL oor_nz: got %h expected 0", rd_nz);
      end
      checks++;
      if (rd[31:0] !== 32'h00000BAD) begin
         errors++; $display("FAIL oor_inrange32: got %h expected 00000bad", rd[31:0]);
      end
   endtask

   task automatic test_back_to_back();
      for (int k = 0; k < 4; k++) begin
         if (k % 2 == 0) begin
            A3 = 5'(10 + k); WD3 = 32'hA000 + 32'(k); WE3 = 1'b1; WE4 = 1'b0;
         end else begin
            A4 = 5'(10 + k); WD4 = 32'hA000 + 32'(k); WE4 = 1'b1; WE3 = 1'b0;
         end
         tick();
      end
      WE3 = 1'b0; WE4 = 1'b0;
      set_ra(5'd10, 5'd11);
      checks++;
      if (rd !== {32'hA001, 32'hA000}) begin
         errors++; $display("FAIL b2b_10_11: got %h expected 0000a0010000a000", rd);
      end
      set_ra(5'd12, 5'd13);
      checks++;
      if (rd_nz !== {32'hA003, 32'hA002}) begin
         errors++; $display("FAIL b2b_12_13: got %h expected 0000a0030000a002", rd_nz);
      end
   endtask

   task automatic test_bypass();
      logic [31:0] exp1, exp2;
      A3 = 5'd3; WD3 = 32'h1111; WE3 = 1'b1;
      tick();
      WE3 = 1'b0;
      A4 = 5'd3; WD4 = 32'hABCD; WE4 = 1'b1;
      set_ra(5'd3, 5'd4);
`ifdef RF_BYPASS_EN
      exp1 = 32'hABCD;
`else
      exp1 = 32'h1111;
`endif
      checks++;
      if (rd[31:0] !== exp1) begin
         errors++; $display("FAIL bypass_same_cycle: got %h expected %h", rd[31:0], exp1);
      end
      tick();
      WE4 = 1'b0;
      #1;
      checks++;
      if (rd[31:0] !== 32'hABCD) begin
         errors++; $display("FAIL bypass_after: got %h expected 0000abcd", rd[31:0]);
      end
      A3 = 5'd3; WD3 = 32'h3333; WE3 = 1'b1;
      A4 = 5'd3; WD4 = 32'h4444; WE4 = 1'b1;
      #1;
`ifdef RF_BYPASS_EN
      exp2 = 32'h4444;
`else
      exp2 = 32'hABCD;
`endif
      checks++;
      if (rd[31:0] !== exp2) begin
         errors++; $display("FAIL bypass_prio: got %h expected %h", rd[31:0], exp2);
      end
      WE3 = 1'b0;
      A4 = 5'd0; WD4 = 32'h77;
      set_ra(5'd0, 5'd3);
      checks++;
      if (rd[31:0] !== 32'h0) begin
         errors++; $display("FAIL bypass_zero: got %h expected 0", rd[31:0]);
      end
      WE4 = 1'b0;
      tick();
   endtask

   task automatic test_mid_reset();
      int n32, n24;
      A3 = 5'd9; WD3 = 32'h55; WE3 = 1'b1;
      tick();
      WE3 = 1'b0;
      set_ra(5'd9, 5'd2);
      checks++;
      if (rd[31:0] !== 32'h55) begin
         errors++; $display("FAIL mid_pre_r9: got %h expected 00000055", rd[31:0]);
      end
      RST = 1'b1;
      tick();
      RST = 1'b0;
      #1;
      checks++;
      if (ready !== 1'b0 || rd !== 64'h0) begin
         errors++; $display("FAIL mid_gate: got ready=%b rd=%h expected 0/0", ready, rd);
      end
      for (int k = 0; k < 10; k++) tick();
      RST = 1'b1;
      tick();
      RST = 1'b0;
      checks++;
      if (ready !== 1'b0 || ready_nz !== 1'b0) begin
         errors++; $display("FAIL mid_ready: got %b/%b expected 0/0", ready, ready_nz);
      end
      for (int k = 0; k < 5; k++) tick();
      A3 = 5'd2; WD3 = 32'hEE; WE3 = 1'b1;
      tick();
      WE3 = 1'b0;
      wait_ready(n32, n24);
      checks++;
      if (n32 != 26 || n24 != 18) begin
         errors++; $display("FAIL mid_clear_len: got %0d/%0d expected 26/18", n32, n24);
      end
      set_ra(5'd9, 5'd2);
      checks++;
      if (rd !== 64'h0 || rd_nz !== 64'h0) begin
         errors++; $display("FAIL mid_cleared: got %h/%h expected 0", rd, rd_nz);
      end
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_zero_reg();
      test_collision();
      test_out_of_range();
      test_back_to_back();
      test_bypass();
      test_mid_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
